// File: rtl/datapath_channel_pkg.sv
// Shared widths, pixel types and the saturation helper for the per-channel
// gamma -> contrast -> brightness datapath.
package datapath_channel_pkg;

    localparam int PADDR = 8;
    localparam int PDATA = 8;

    typedef logic [7:0]         color_t;
    typedef logic signed [8:0]  color_signed_t;
    typedef logic signed [13:0] contrast_fp_t;
    typedef logic [19:0]        cp_param_t;

    localparam color_t PIX_MAX = 8'd255;

    // Clamp a wide signed intermediate into the legal pixel range.
    function automatic color_t sat_pix(input contrast_fp_t v);
        if (v < 14'sd0)
            return 8'h00;
        else if (v > $signed({6'b0, PIX_MAX}))
            return PIX_MAX;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/datapath_channel_gamma_lut.sv
// 256x8 gamma table: one write port, combinational read, identity on reset.
module datapath_channel_gamma_lut
    import datapath_channel_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             we_n,
    input  logic [PADDR-1:0] waddr,
    input  logic [PDATA-1:0] wdata,
    input  logic [PADDR-1:0] raddr,
    output logic [PDATA-1:0] rdata
);

    logic [PDATA-1:0] mem_q [256];
    logic [PDATA-1:0] mem_d [256];

    always_comb begin
        mem_d = mem_q;
        if (!we_n)
            mem_d[waddr] = wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < 256; i++)
                mem_q[i] <= PDATA'(i);
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read sees the pre-edge contents, so a same-address write returns old data.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/datapath_channel.sv
// Three-stage pixel channel (gamma, contrast, brightness); the whole pipe
// freezes when downstream is not ready and enables ride along with each pixel.
module datapath_channel
    import datapath_channel_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             glut_write_en_n,
    input  logic [PADDR-1:0] glut_from,
    input  logic [PDATA-1:0] glut_to,
    input  logic             g_en,
    input  logic             c_en,
    input  logic             b_en,
    input  logic             datapath_ready,
    input  color_t           color_in,
    input  logic             color_in_valid,
    input  cp_param_t        cp_param,
    input  color_signed_t    brightness_param,
    output color_t           color_out,
    output logic             color_out_valid
);

    color_t       gamma_rd;
    color_t       s1_data_q, s1_data_d;
    color_t       s2_data_q, s2_data_d;
    color_t       s3_data_q, s3_data_d;
    logic [2:0]   vld_q, vld_d;
    logic         c1_en_q, c1_en_d;
    logic         b1_en_q, b1_en_d;
    logic         b2_en_q, b2_en_d;
    logic [15:0]  ct_prod;
    contrast_fp_t ct_sum;
    contrast_fp_t br_sum;

    datapath_channel_gamma_lut u_gamma (
        .clk    (clk),
        .resetN (resetN),
        .we_n   (glut_write_en_n),
        .waddr  (glut_from),
        .wdata  (glut_to),
        .raddr  (color_in),
        .rdata  (gamma_rd)
    );

    // gain is unsigned Q4.4, so drop four fraction bits before adding offset
    assign ct_prod = {8'b0, s1_data_q} * {8'b0, cp_param[19:12]};
    assign ct_sum  = $signed({2'b00, ct_prod[15:4]}) + $signed({{2{cp_param[11]}}, cp_param[11:0]});
    assign br_sum  = $signed({6'b0, s2_data_q}) + $signed({{5{brightness_param[8]}}, brightness_param});

    always_comb begin
        s1_data_d = s1_data_q;
        s2_data_d = s2_data_q;
        s3_data_d = s3_data_q;
        vld_d     = vld_q;
        c1_en_d   = c1_en_q;
        b1_en_d   = b1_en_q;
        b2_en_d   = b2_en_q;
        if (datapath_ready) begin
            s1_data_d = g_en ? gamma_rd : color_in;
            c1_en_d   = c_en;
            b1_en_d   = b_en;
            s2_data_d = c1_en_q ? sat_pix(ct_sum) : s1_data_q;
            b2_en_d   = b1_en_q;
            s3_data_d = b2_en_q ? sat_pix(br_sum) : s2_data_q;
            vld_d     = {vld_q[1:0], color_in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            s1_data_q <= '0;
            s2_data_q <= '0;
            s3_data_q <= '0;
            vld_q     <= '0;
            c1_en_q   <= 1'b0;
            b1_en_q   <= 1'b0;
            b2_en_q   <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
            s3_data_q <= s3_data_d;
            vld_q     <= vld_d;
            c1_en_q   <= c1_en_d;
            b1_en_q   <= b1_en_d;
            b2_en_q   <= b2_en_d;
        end
    end

    assign color_out       = s3_data_q;
    assign color_out_valid = vld_q[2];

endmodule

// File: tb/tb_datapath_channel.sv
// Directed bench: driver pushes hand-computed results, negedge monitor pops and compares.
module tb_datapath_channel;

    logic        clk = 1'b0;
    logic        resetN;
    logic        glut_write_en_n;
    logic [7:0]  glut_from, glut_to;
    logic        g_en, c_en, b_en;
    logic        datapath_ready;
    logic [7:0]  color_in;
    logic        color_in_valid;
    logic [19:0] cp_param;
    logic [8:0]  brightness_param;
    logic [7:0]  color_out;
    logic        color_out_valid;

    typedef struct {
        logic [7:0] d;
        int         issue;
        bit         lat;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] hold_d;
    logic       hold_v;

    datapath_channel dut (
        .clk              (clk),
        .resetN           (resetN),
        .glut_write_en_n  (glut_write_en_n),
        .glut_from        (glut_from),
        .glut_to          (glut_to),
        .g_en             (g_en),
        .c_en             (c_en),
        .b_en             (b_en),
        .datapath_ready   (datapath_ready),
        .color_in         (color_in),
        .color_in_valid   (color_in_valid),
        .cp_param         (cp_param),
        .brightness_param (brightness_param),
        .color_out        (color_out),
        .color_out_valid  (color_out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // An output is consumed on the next edge only when downstream is ready.
    always @(negedge clk) begin
        if (resetN === 1'b1 && color_out_valid === 1'b1 && datapath_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0h expected none", color_out);
            end else begin
                mon_e = sb.pop_front();
                chk("pixel", int'(color_out), int'(mon_e.d));
                if (mon_e.lat)
                    chk("latency", cyc - mon_e.issue, 3);
            end
        end
    end

    task automatic send(input logic [7:0] px, input bit g, input bit c, input bit b,
                        input logic [7:0] exp, input bit lat = 1'b0);
        @(posedge clk); #1;
        glut_write_en_n = 1'b1;
        color_in = px; color_in_valid = 1'b1;
        g_en = g; c_en = c; b_en = b;
        if (datapath_ready) sb.push_back('{exp, cyc, lat});
    endtask

    task automatic idle();
        @(posedge clk); #1;
        color_in_valid  = 1'b0;
        glut_write_en_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetN = 1'b0;
        color_in_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_data", int'(color_out), 0);
        chk("reset_valid", int'(color_out_valid), 0);
        @(posedge clk); #1;
        resetN = 1'b1;
    endtask

    initial begin
        resetN = 1'b0; glut_write_en_n = 1'b1; glut_from = '0; glut_to = '0;
        g_en = 0; c_en = 0; b_en = 0; datapath_ready = 1'b1;
        color_in = '0; color_in_valid = 1'b0;
        cp_param = '0; brightness_param = '0;

        do_reset();

        // bypass with latency check
        send(8'h5A, 0, 0, 0, 8'h5A, 1'b1);
        drain();

        // untouched gamma table is identity
        send(8'h33, 1, 0, 0, 8'h33);
        send(8'hC7, 1, 0, 0, 8'hC7);
        drain();

        // load inverted gamma
        for (int i = 0; i < 256; i++) begin
            @(posedge clk); #1;
            glut_write_en_n = 1'b0;
            glut_from = 8'(i);
            glut_to   = 8'(255 - i);
        end
        idle();
        send(8'h10, 1, 0, 0, 8'hEF);
        send(8'h00, 1, 0, 0, 8'hFF);
        // read and write same entry on one edge returns the old value
        @(posedge clk); #1;
        glut_write_en_n = 1'b0; glut_from = 8'h10; glut_to = 8'h55;
        color_in = 8'h10; color_in_valid = 1'b1; g_en = 1; c_en = 0; b_en = 0;
        sb.push_back('{8'hEF, cyc, 1'b0});
        send(8'h10, 1, 0, 0, 8'h55);
        drain();

        // contrast: gain 2.0, offset -128; last pixel checks enable travels
        cp_param = {8'h20, 12'hF80};
        send(8'hA0, 0, 1, 0, 8'hC0);
        send(8'hF0, 0, 1, 0, 8'hFF);
        send(8'h30, 0, 1, 0, 8'h00);
        send(8'hA0, 0, 0, 0, 8'hA0);
        drain();

        // brightness
        brightness_param = 9'h1F7;
        send(8'h80, 0, 0, 1, 8'h77);
        send(8'h05, 0, 0, 1, 8'h00);
        drain();
        brightness_param = 9'd100;
        send(8'hC8, 0, 0, 1, 8'hFF);
        drain();

        // stall mid-stream: outputs hold, offered pixels dropped
        for (int i = 1; i <= 4; i++) send(8'(i), 0, 0, 0, 8'(i));
        @(posedge clk); #1;
        datapath_ready = 1'b0; color_in = 8'hE1; color_in_valid = 1'b1;
        @(negedge clk);
        hold_d = color_out; hold_v = color_out_valid;
        chk("stall_valid_present", int'(hold_v), 1);
        @(posedge clk); #1;
        color_in = 8'hE2;
        @(negedge clk);
        chk("stall_hold_data", int'(color_out), int'(hold_d));
        chk("stall_hold_valid", int'(color_out_valid), int'(hold_v));
        @(posedge clk); #1;
        datapath_ready = 1'b1; color_in_valid = 1'b0;
        for (int i = 5; i <= 8; i++) send(8'(i), 0, 0, 0, 8'(i));
        drain();

        // reset mid-frame discards in-flight pixels and restores identity gamma
        send(8'h11, 0, 0, 0, 8'h11);
        send(8'h22, 0, 0, 0, 8'h22);
        do_reset();
        brightness_param = 9'h1F7;
        send(8'h10, 1, 0, 0, 8'h10);
        send(8'hA0, 1, 1, 1, 8'hB7);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
